var_shift_reg: RTL and testbench

- Registered, variable-amount, bidirectional logical barrel shifter.
- Each enabled clock, `q` captures `in` shifted left or right by `shift` bit positions.
- Used wherever a datapath needs a one-cycle shifted copy of a word, with a runtime-selectable amount and direction.

---
 rtl/var_shift_pkg.sv | 11 +
 rtl/var_shift_core.sv | 37 +++
 rtl/var_shift_reg.sv | 44 ++++
 tb/tb_var_shift_reg.sv | 130 +++++++++++++
 4 files changed

// File: rtl/var_shift_pkg.sv
// Shared constants for the registered variable barrel shifter.
// The direction encodings and default sizes are kept here so every user agrees on them.
package var_shift_pkg;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam int VS_WIDTH = 32;
    localparam int VS_SHW   = 6;

endpackage : var_shift_pkg

// File: rtl/var_shift_core.sv
// Combinational logarithmic barrel shifter, logical left or right.
// Right shifts reuse the left-shift stages by reversing the word on the way in and out.
module var_shift_core
    import var_shift_pkg::*;
#(
    parameter int WIDTH = VS_WIDTH,
    parameter int SHW   = VS_SHW
) (
    input  logic [WIDTH-1:0] in,
    input  logic [SHW-1:0]   shift,
    input  logic             dir,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] rev_in_s;
    logic [WIDTH-1:0] rev_out_s;
    logic [WIDTH-1:0] stage_s [0:SHW];

    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign rev_in_s[i]  = in[WIDTH-1-i];
        assign rev_out_s[i] = stage_s[SHW][WIDTH-1-i];
    end

    assign stage_s[0] = (dir == DIR_RIGHT) ? rev_in_s : in;

    // Stages whose weight reaches WIDTH flush the word instead of wrapping.
    for (genvar k = 0; k < SHW; k++) begin : g_stage
        if ((2 ** k) >= WIDTH) begin : g_flush
            assign stage_s[k+1] = shift[k] ? {WIDTH{1'b0}} : stage_s[k];
        end else begin : g_shift
            assign stage_s[k+1] = shift[k] ? (stage_s[k] << (2 ** k)) : stage_s[k];
        end
    end

    assign out = (dir == DIR_RIGHT) ? rev_out_s : stage_s[SHW];

endmodule : var_shift_core

// File: rtl/var_shift_reg.sv
// Registered variable-amount bidirectional logical shifter.
// Only q is stored; clr wins over en, and en low holds the previous result.
module var_shift_reg
    import var_shift_pkg::*;
#(
    parameter int WIDTH = VS_WIDTH,
    parameter int SHW   = VS_SHW
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             dir,
    input  logic             en,
    input  logic [WIDTH-1:0] in,
    input  logic [SHW-1:0]   shift,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] shifted_s;
    logic [WIDTH-1:0] q_r;

    var_shift_core #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_core (
        .in    (in),
        .shift (shift),
        .dir   (dir),
        .out   (shifted_s)
    );

    // Result register with synchronous clear priority over load.
    always_ff @(posedge clk) begin
        if (clr) begin
            q_r <= {WIDTH{1'b0}};
        end else if (en) begin
            q_r <= shifted_s;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule : var_shift_reg

// File: tb/tb_var_shift_reg.sv
// Self-checking bench for var_shift_reg: directed literal cases plus
// randomized traffic compared every cycle against an arithmetic reference.
module tb_var_shift_reg;

    logic        clk;
    logic        clr;
    logic        dir;
    logic        en;
    logic [31:0] in;
    logic [5:0]  shift;
    logic [31:0] q;

    int n_cmp = 0;
    int n_mis = 0;

    logic [31:0] exp_q;
    logic        exp_valid = 1'b0;

    var_shift_reg #(.WIDTH(32), .SHW(6)) dut (
        .clk   (clk),
        .clr   (clr),
        .dir   (dir),
        .en    (en),
        .in    (in),
        .shift (shift),
        .q     (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_shift(input logic [31:0] v, input logic d, input logic [5:0] s);
        int amt;
        amt = int'(s);
        if (amt >= 32) return 32'h0;
        if (d) return v >> amt;
        return v << amt;
    endfunction

    // Reference model: what q must hold after each rising edge.
    always @(posedge clk) begin
        if (clr) begin
            exp_q     = 32'h0;
            exp_valid = 1'b1;
        end else if (en) begin
            exp_q = ref_shift(in, dir, shift);
        end
    end

    // Per-cycle comparison of the DUT against the model, away from the active edge.
    always @(negedge clk) begin
        if (exp_valid) begin
            n_cmp++;
            if (q !== exp_q) begin
                n_mis++;
                $display("FAIL cycle_check t=%0t q=%08h expected=%08h", $time, q, exp_q);
            end
        end
    end

    task automatic step(input logic c, input logic e, input logic d,
                        input logic [31:0] i, input logic [5:0] s);
        clr   = c;
        en    = e;
        dir   = d;
        in    = i;
        shift = s;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_lit(input string name, input logic [31:0] want);
        n_cmp++;
        if (q !== want) begin
            n_mis++;
            $display("FAIL %s dut q=%08h required=%08h", name, q, want);
        end
        n_cmp++;
        if (exp_q !== want) begin
            n_mis++;
            $display("FAIL %s_model model=%08h required=%08h", name, exp_q, want);
        end
    endtask

    initial begin
        clr = 1'b1; en = 1'b1; dir = 1'b0; in = 32'h0; shift = 6'd0;

        step(1'b1, 1'b1, 1'b0, 32'h0000_01A6, 6'd0);  check_lit("reset", 32'h0000_0000);
        step(1'b0, 1'b1, 1'b0, 32'h0000_01A6, 6'd0);  check_lit("no_shift", 32'h0000_01A6);
        step(1'b0, 1'b1, 1'b0, 32'h0000_01A6, 6'd4);  check_lit("left4", 32'h0000_1A60);
        step(1'b0, 1'b1, 1'b0, 32'h0000_01A6, 6'd24); check_lit("left24", 32'hA600_0000);
        step(1'b0, 1'b1, 1'b1, 32'h0000_01A6, 6'd4);  check_lit("right4", 32'h0000_001A);
        step(1'b0, 1'b1, 1'b1, 32'h0000_01A6, 6'd8);  check_lit("right8", 32'h0000_0001);
        step(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 6'd32); check_lit("left32", 32'h0000_0000);
        step(1'b0, 1'b1, 1'b0, 32'h0000_0001, 6'd31); check_lit("left31", 32'h8000_0000);
        step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 6'd32); check_lit("right32", 32'h0000_0000);
        step(1'b0, 1'b1, 1'b0, 32'h8000_0001, 6'd31); check_lit("left31_b", 32'h8000_0000);
        step(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 6'd63); check_lit("left63", 32'h0000_0000);
        step(1'b0, 1'b1, 1'b1, 32'h8000_0000, 6'd31); check_lit("right31", 32'h0000_0001);
        step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 6'd63); check_lit("right63", 32'h0000_0000);
        step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 6'd33); check_lit("right33", 32'h0000_0000);

        step(1'b0, 1'b1, 1'b0, 32'h0000_01A6, 6'd4);  check_lit("hold_load", 32'h0000_1A60);
        for (int h = 0; h < 3; h++) begin
            step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 6'd1);
            check_lit("hold", 32'h0000_1A60);
        end
        step(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 6'd0);  check_lit("clr_over_en", 32'h0000_0000);
        step(1'b0, 1'b1, 1'b1, 32'hF000_0000, 6'd28); check_lit("after_clr", 32'h0000_000F);

        for (int r = 0; r < 3000; r++) begin
            logic [5:0] s;
            logic [31:0] v;
            case ($urandom_range(0, 5))
                0:       s = 6'd0;
                1:       s = 6'd31;
                2:       s = 6'd32;
                3:       s = 6'($urandom_range(32, 63));
                default: s = 6'($urandom_range(0, 63));
            endcase
            v = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), v, s);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_var_shift_reg
